// File: rtl/roe_pkg.sv
// Shared types for the R.O.E pipeline decode/control/ALU.
// Encoding: instr = {op[2:0], fun2[1:0], low[INSTR_W-6:0]}; fun1 = fun2[0].
package roe_pkg;

    localparam int NUM_SETS = 4;
    localparam int SET_W    = $clog2(NUM_SETS);

    typedef enum logic [2:0] {
        OP_REG, OP_ARITH, OP_SHIFT, OP_SLT,
        OP_XOR, OP_AND, OP_OR, OP_HARD
    } op_code;

    typedef enum logic [1:0] {
        FN_LW, FN_SW, FN_BRANCH, FN_REDEF
    } func_code;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SHIFTL, ALU_SHIFTR, ALU_SLB,
        ALU_SLT, ALU_XOR, ALU_AND, ALU_OR
    } alu_op_t;

    typedef struct packed {
        logic [SET_W-1:0] set_read0;
        logic [SET_W-1:0] set_read1;
        logic [SET_W-1:0] set_write;
        logic             reg_imm;
        logic             reg_write_src;
        logic             mem_write;
        logic             mem_read;
        alu_op_t          alu_op;
        logic [1:0]       alu_src;
        logic             reg_write;
        logic             reg_read_write;
        logic             reg_write_read;
        logic             branch;
    } ctrl_t;

    typedef enum logic [1:0] {
        RUN, BUBBLE, FLUSH
    } dec_state_t;

endpackage

// File: rtl/roe_decode_comb.sv
// Pure combinational decode: op/fun bits + window pointers -> ctrl_t.
// Ports: opf (op,fun2), ptr_r0/r1/w in; ctrl, is_redef, is_lw, is_branch out.
module roe_decode_comb
    import roe_pkg::*;
(
    input  logic [4:0]       opf,
    input  logic [SET_W-1:0] ptr_r0,
    input  logic [SET_W-1:0] ptr_r1,
    input  logic [SET_W-1:0] ptr_w,
    output ctrl_t            ctrl,
    output logic             is_redef,
    output logic             is_lw,
    output logic             is_branch
);

    op_code   op;
    func_code fn;
    logic     fun1;

    assign op   = op_code'(opf[4:2]);
    assign fn   = func_code'(opf[1:0]);
    assign fun1 = opf[0];

    always_comb begin
        ctrl           = '0;
        is_redef       = 1'b0;
        is_lw          = 1'b0;
        is_branch      = 1'b0;
        ctrl.set_read0 = ptr_r0;
        ctrl.set_read1 = ptr_r1;
        ctrl.set_write = ptr_w;
        unique case (op)
            OP_REG: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 2'b01;
                ctrl.alu_op    = ALU_SLB;
            end
            OP_ARITH, OP_SHIFT: begin
                ctrl.reg_imm        = 1'b1;
                ctrl.reg_read_write = 1'b1;
                ctrl.reg_write_read = 1'b1;
                ctrl.reg_write      = 1'b1;
                if (op == OP_ARITH)
                    ctrl.alu_op = fun1 ? ALU_SUB : ALU_ADD;
                else
                    ctrl.alu_op = fun1 ? ALU_SHIFTR : ALU_SHIFTL;
            end
            OP_SLT: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_SLT;
            end
            OP_XOR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_XOR;
            end
            OP_AND: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_AND;
            end
            OP_OR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_OR;
            end
            OP_HARD: begin
                unique case (fn)
                    FN_LW: begin
                        is_lw              = 1'b1;
                        ctrl.mem_read      = 1'b1;
                        ctrl.reg_write     = 1'b1;
                        ctrl.reg_write_src = 1'b1;
                        ctrl.alu_op        = ALU_ADD;
                    end
                    FN_SW: begin
                        ctrl.mem_write = 1'b1;
                        ctrl.alu_op    = ALU_ADD;
                    end
                    FN_BRANCH: begin
                        is_branch   = 1'b1;
                        ctrl.branch = 1'b1;
                        ctrl.alu_op = ALU_SUB;
                    end
                    FN_REDEF: begin
                        is_redef = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/roe_decode_stage.sv
// Registered decode stage: FSM (RUN/BUBBLE/FLUSH), window pointers, output reg.
// Ports: clk, rst_n, in_valid/in_ready/instr from fetch; out_valid/out_ready/ctrl_out to execute; flushing.
module roe_decode_stage
    import roe_pkg::*;
#(
    parameter int INSTR_W     = 9,
    parameter int FLUSH_SLOTS = 1,
    parameter int LOAD_BUBBLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output ctrl_t              ctrl_out,
    output logic               flushing
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_SLOTS);

    dec_state_t       state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic [SET_W-1:0] ptr_r0_q, ptr_r0_d;
    logic [SET_W-1:0] ptr_r1_q, ptr_r1_d;
    logic [SET_W-1:0] ptr_w_q, ptr_w_d;
    logic             out_valid_q, out_valid_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             flushing_q, flushing_d;

    ctrl_t            dec_ctrl;
    logic             is_redef, is_lw, is_branch;
    logic             fire_in;
    logic [SET_W-1:0] redef_val;

    roe_decode_comb u_comb (
        .opf       (instr[INSTR_W-1 -: 5]),
        .ptr_r0    (ptr_r0_q),
        .ptr_r1    (ptr_r1_q),
        .ptr_w     (ptr_w_q),
        .ctrl      (dec_ctrl),
        .is_redef  (is_redef),
        .is_lw     (is_lw),
        .is_branch (is_branch)
    );

    assign redef_val = instr[SET_W-1:0];

    always_comb begin
        in_ready    = (state_q != BUBBLE) & (~out_valid_q | out_ready);
        fire_in     = in_valid & in_ready;
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        ptr_r0_d    = ptr_r0_q;
        ptr_r1_d    = ptr_r1_q;
        ptr_w_d     = ptr_w_q;
        ctrl_d      = ctrl_q;
        out_valid_d = out_valid_q & ~out_ready;
        unique case (state_q)
            RUN: begin
                if (fire_in) begin
                    if (is_redef) begin
                        unique case (instr[3:2])
                            2'b00: ptr_r0_d = redef_val;
                            2'b01: ptr_r1_d = redef_val;
                            2'b10: ptr_w_d  = redef_val;
                            2'b11: begin
                                ptr_r0_d = redef_val;
                                ptr_r1_d = redef_val;
                                ptr_w_d  = redef_val;
                            end
                        endcase
                    end else begin
                        out_valid_d = 1'b1;
                        ctrl_d      = dec_ctrl;
                        if (is_lw && LOAD_BUBBLE != 0) begin
                            state_d = BUBBLE;
                        end else if (is_branch && FLUSH_SLOTS > 0) begin
                            state_d     = FLUSH;
                            flush_cnt_d = FLUSH_INIT;
                        end
                    end
                end
            end
            BUBBLE: state_d = RUN;
            FLUSH: begin
                // Squashed slot: counts down only, no side effects.
                if (fire_in) begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q <= 3'd1)
                        state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        flushing_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            ptr_r0_q    <= '0;
            ptr_r1_q    <= '0;
            ptr_w_q     <= '0;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            flushing_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            ptr_r0_q    <= ptr_r0_d;
            ptr_r1_q    <= ptr_r1_d;
            ptr_w_q     <= ptr_w_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            flushing_q  <= flushing_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ctrl_out  = ctrl_q;
    assign flushing  = flushing_q;

endmodule
